// File: rtl/timer_pkg.sv
// Shared types and register map for the multi-channel timer array.
// Register offsets are word indices within a channel's 16-byte window.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_DIV  = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: registers, prescaler and the IDLE/LOAD/CNT/INT FSM.
// Write ordering inside the clocked block gives expiry-over-W1C and CPU-over-FSM.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [3:0]       i_byteen,
  input  logic [31:0]      i_wdata,
  input  logic [1:0]       i_sel,
  output logic [3:0][31:0] o_rd,
  output logic             o_irq
);

  state_t               r_state;
  logic                 r_en;
  logic [1:0]           r_mode;
  logic                 r_im;
  logic [PRESC_W-1:0]   r_div;
  logic [CNT_W-1:0]     r_preset;
  logic [CNT_W-1:0]     r_count;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_pend;

  logic [31:0]          w_mask;
  logic                 w_wr_ctrl;
  logic                 w_wr_pre;
  logic                 w_wr_stat;
  logic                 w_tick;
  logic [PRESC_W-1:0]   w_div_m;
  logic [CNT_W-1:0]     w_pre_m;

  assign w_mask = {{8{i_byteen[3]}}, {8{i_byteen[2]}},
                   {8{i_byteen[1]}}, {8{i_byteen[0]}}};

  assign w_wr_ctrl = i_we && (i_sel == REG_CTRL);
  assign w_wr_pre  = i_we && (i_sel == REG_PRESET);
  assign w_wr_stat = i_we && (i_sel == REG_STATUS);
  assign w_tick    = (r_presc == r_div);

  assign w_div_m = (r_div & ~w_mask[CTRL_DIV +: PRESC_W])
                 | (i_wdata[CTRL_DIV +: PRESC_W]
                    & w_mask[CTRL_DIV +: PRESC_W]);
  assign w_pre_m = (r_preset & ~w_mask[CNT_W-1:0])
                 | (i_wdata[CNT_W-1:0] & w_mask[CNT_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_im     <= 1'b0;
      r_div    <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_presc  <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (w_wr_stat && i_byteen[0] && i_wdata[0])
        r_pend <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (r_en)
            r_state <= LOAD;
        end
        LOAD: begin
          r_count <= r_preset;
          r_presc <= '0;
          r_state <= CNT;
        end
        CNT: begin
          if (!r_en) begin
            r_state <= IDLE;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
              if (r_count > CNT_W'(1)) begin
                r_count <= r_count - CNT_W'(1);
              end else begin
                r_count <= '0;
                r_pend  <= 1'b1;
                r_state <= INT;
              end
            end
          end
        end
        INT: begin
          if (r_mode == MODE_RELOAD) begin
            r_state <= LOAD;
          end else begin
            r_en    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Placed after the FSM so a same-cycle CPU write of EN takes effect.
      if (w_wr_ctrl && i_byteen[0]) begin
        r_en   <= i_wdata[CTRL_EN];
        r_mode <= i_wdata[CTRL_MODE +: 2];
        r_im   <= i_wdata[CTRL_IM];
      end
      if (w_wr_ctrl)
        r_div <= w_div_m;
      if (w_wr_pre)
        r_preset <= w_pre_m;
    end
  end

  always_comb begin
    o_rd = '0;
    o_rd[REG_CTRL][CTRL_EN]             = r_en;
    o_rd[REG_CTRL][CTRL_MODE +: 2]      = r_mode;
    o_rd[REG_CTRL][CTRL_IM]             = r_im;
    o_rd[REG_CTRL][CTRL_DIV +: PRESC_W] = r_div;
    o_rd[REG_PRESET][CNT_W-1:0]         = r_preset;
    o_rd[REG_COUNT][CNT_W-1:0]          = r_count;
    o_rd[REG_STATUS][0]                 = r_pend;
  end

  assign o_irq = r_pend & r_im;

endmodule

// File: rtl/timer_array.sv
// N_CH-channel down-counter peripheral behind a single register window.
// Channel select is addr[4 +: log2(N_CH)]; out-of-range channels read 0.
module timer_array
  import timer_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]  w_ch;
  logic [1:0]       w_sel;
  logic [N_CH-1:0]  w_hit;
  logic [3:0][31:0] w_rd [N_CH];
  logic             w_unused;

  assign w_sel    = addr[3:2];
  assign w_unused = ^{addr[31:4+CH_W], addr[1:0]};

  if (N_CH > 1) begin : g_multi
    assign w_ch = addr[4 +: CH_W];
  end else begin : g_single
    assign w_ch = '0;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_hit[g] = (w_ch == CH_W'(g));

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_we     (we && w_hit[g]),
      .i_byteen (byteen),
      .i_wdata  (wdata),
      .i_sel    (w_sel),
      .o_rd     (w_rd[g]),
      .o_irq    (irq[g])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++)
      if (w_hit[i])
        rdata = w_rd[i][w_sel];
  end

endmodule
